// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int              BCD_DIGIT_W = 4;
  localparam logic [3:0]      ADJ_THRESH  = 4'd5;
  localparam logic [3:0]      ADJ_ADD     = 4'd3;

  // Decimal digits needed to represent the largest in_w-bit unsigned value.
  function automatic int digits_needed(input int in_w);
    longint unsigned v;
    int n;
    v = (64'd1 << in_w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_adj3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// before the shift so that it carries correctly into the next digit.
module bcd_digit_adj3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  // Add-3 correction when the digit would overflow 9 after doubling.
  always_comb begin
    if (i_digit >= ADJ_THRESH) begin
      o_digit = i_digit + ADJ_ADD;
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per cycle, val/rdy on both sides.
// Optional leading-zero blank mask output enabled by defining BIN2BCD_BLANK_EN.
module bin_to_bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_val,
  output logic                              in_rdy,
  input  logic [IN_WIDTH-1:0]               in_bin,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] out_bcd
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [NUM_DIGITS-1:0]             out_blank
`endif
);

  localparam int BCD_W  = BCD_DIGIT_W * NUM_DIGITS;
  localparam int WORK_W = BCD_W + IN_WIDTH;
  localparam int CNT_W  = $clog2(IN_WIDTH + 1);

  if (IN_WIDTH < 1 || IN_WIDTH > 32 || NUM_DIGITS < digits_needed(IN_WIDTH)) begin : g_param_err
    $error("bin_to_bcd_seq: IN_WIDTH must be 1..32 and NUM_DIGITS wide enough for 2**IN_WIDTH-1");
  end

  state_e             r_state;
  logic [WORK_W-1:0]  r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_rdy;
  logic               r_out_val;
  logic [BCD_W-1:0]   r_out_bcd;

  logic [BCD_W-1:0]   w_adj_bcd;
  logic [WORK_W-1:0]  w_shifted;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj3 u_adj (
      .i_digit (r_work[IN_WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .o_digit (w_adj_bcd[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // The top digit's carry falls off the left end; the parameter check rules it out.
  assign w_shifted = {w_adj_bcd, r_work[IN_WIDTH-1:0]} << 1;

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_work    <= '0;
      r_cnt     <= '0;
      r_in_rdy  <= 1'b0;
      r_out_val <= 1'b0;
      r_out_bcd <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_rdy  <= 1'b1;
          r_out_val <= 1'b0;
          if (in_val && r_in_rdy) begin
            r_work   <= {{BCD_W{1'b0}}, in_bin};
            r_cnt    <= CNT_W'(IN_WIDTH);
            r_in_rdy <= 1'b0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_in_rdy  <= 1'b0;
          r_work    <= w_shifted;
          r_cnt     <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_out_bcd <= w_shifted[WORK_W-1 -: BCD_W];
            r_out_val <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_rdy) begin
            r_out_val <= 1'b0;
            r_in_rdy  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_in_rdy  <= 1'b0;
          r_out_val <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign in_rdy  = r_in_rdy;
  assign out_val = r_out_val;
  assign out_bcd = r_out_bcd;

`ifdef BIN2BCD_BLANK_EN
  // Blank digit i (i>=1) when it and every digit above it are zero.
  always_comb begin
    logic hi_zero;
    out_blank = '0;
    hi_zero   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (r_out_bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W] != 4'd0) begin
        hi_zero = 1'b0;
      end else begin
        hi_zero = hi_zero;
      end
      out_blank[i] = r_out_val & hi_zero;
    end
  end
`endif

endmodule
